// File: rtl/divider.sv
// Sequential unsigned fixed-point divider: quotient = floor((a << FRAC) / b),
// restoring division, one quotient bit per clock, start/accept/done handshake.
//
// state | meaning
// IDLE  | waiting for available; status mirrors available
// INIT  | check divide-by-zero / overflow, seed partial remainder and numerator
// CALC  | one restoring-division step per cycle, WIDTH cycles
// DONE  | one-cycle done pulse, results already registered
module divider #(
  parameter int WIDTH = 24,
  parameter int FRAC  = 23
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             available,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             status,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SH = WIDTH - FRAC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] r_init;
  logic [WIDTH-1:0] sr_init;
  logic [WIDTH:0]   r_shift;
  logic             q_bit;
  logic [WIDTH-1:0] r_next;

  // Upper WIDTH bits of the 2*WIDTH-bit numerator seed the remainder; the
  // quotient overflows exactly when that seed is already >= b.
  assign r_init  = a_q >> SH;
  assign sr_init = a_q << FRAC;

  // r stays below b, so a successful subtraction always fits in WIDTH bits.
  assign r_shift = {r_q, sr_q[WIDTH-1]};
  assign q_bit   = (r_shift >= {1'b0, b_q});
  assign r_next  = q_bit ? (r_shift[WIDTH-1:0] - b_q) : r_shift[WIDTH-1:0];

  assign status = (state_q == IDLE) && available;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      sr_q        <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (available) begin
            a_q     <= a;
            b_q     <= b;
            state_q <= INIT;
          end
        end
        INIT: begin
          if (b_q == '0) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
            done        <= 1'b1;
            state_q     <= DONE;
          end else if (r_init >= b_q) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
            done        <= 1'b1;
            state_q     <= DONE;
          end else begin
            r_q     <= r_init;
            sr_q    <= sr_init;
            cnt_q   <= CW'(WIDTH - 1);
            state_q <= CALC;
          end
        end
        CALC: begin
          r_q  <= r_next;
          sr_q <= {sr_q[WIDTH-2:0], q_bit};
          if (cnt_q == '0) begin
            quotient    <= {sr_q[WIDTH-2:0], q_bit};
            remainder   <= r_next;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            done        <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
